uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single byte-wide UART transmitter between several message sources (answer printer, timer report, result banner). Arbitration is round-robin at message granularity: a granted source owns the transmitter until it sends its last byte or stalls past a timeout. A programmable inter-message gap separates messages on the serial line.

Parameters:
N_REQ, 3, number of requesters (2..8)
DATA_W, 8, byte width
GAP_CYCLES, 16, idle clocks between messages (0 = no gap)
TIMEOUT, 1000000, clocks a granted source may leave req_valid low before the grant is revoked

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
req  input  N_REQ  per-source request to send a message
req_data  input  N_REQ*DATA_W  per-source byte; source i at [i*DATA_W +: DATA_W]
req_valid  input  N_REQ  per-source byte valid
req_last  input  N_REQ  per-source "this byte ends the message"
req_ready  output  N_REQ  per-source byte accepted; only the granted bit can be 1
grant  output  N_REQ  one-hot owner, registered
tx_data  output  DATA_W  byte to the transmitter
tx_valid  output  1  byte valid to the transmitter
tx_ready  input  1  transmitter can accept a byte
busy  output  1  high in GRANT or GAP
msg_done  output  1  one-cycle pulse when a last byte is accepted
abort  output  1  one-cycle pulse on timeout revocation

Behaviour:
- Reset values: grant=0, req_ready=0, tx_valid=0, tx_data=0, busy=0, msg_done=0, abort=0. Internal state: state=IDLE, rr_ptr=N_REQ-1 (source 0 wins first), gap_cnt=0, to_cnt=0.
- FSM states: IDLE, GRANT, GAP.
- IDLE: if any req bit is set, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ). Next cycle: grant=onehot(winner), rr_ptr=winner, state=GRANT. Latency from req to grant is 1 clock. If no req bit is set, stay in IDLE.
- GRANT: transmit path is combinational from the owner g.
  - tx_valid=req_valid[g], tx_data=req_data[g], req_ready[g]=tx_ready; all other req_ready bits are 0.
  - A byte transfers when tx_valid and tx_ready are both high.
  - Transfer with req_last[g]=1: msg_done pulses in the same cycle. Next cycle grant=0 and state=GAP, with gap_cnt=GAP_CYCLES-1. If GAP_CYCLES=0, the next state is IDLE.
  - Deasserting req[g] during GRANT is ignored; only last or timeout ends ownership.
  - to_cnt clears on every cycle where req_valid[g]=1. Otherwise it increments. If to_cnt reaches TIMEOUT-1 with req_valid[g] low, abort pulses, grant clears next cycle and the FSM enters GAP (or IDLE when GAP_CYCLES=0). The partial message is not flushed; the source is responsible for that.
  - Timeout and last never coincide, because last requires req_valid high.
- GAP: tx_valid=0 and req_ready=0. gap_cnt decrements each cycle. When gap_cnt=0 the next state is IDLE, so a new grant issues no earlier than GAP_CYCLES+1 clocks after the final byte.
- busy = (state != IDLE).
- Fairness: if all sources continuously request, grant order is 0,1,2,0,... Any requesting source waits at most N_REQ-1 messages.
- Reset asserted mid-message: all outputs return to reset values immediately (asynchronous). rr_ptr returns to N_REQ-1. No partial-byte handshake survives.
- tx_data is a don't-care when tx_valid=0. The implementation drives 0 in those cycles so waveforms stay clean.
- Counter widths: $clog2(TIMEOUT) and $clog2(GAP_CYCLES+1), minimum 1 bit.

Decomposition:
- Shared package: FSM state enum {IDLE, GRANT, GAP}; the one-hot/index conversion functions.
- One sub-module: rr_picker, a combinational round-robin priority search taking req and rr_ptr and returning the winner index plus a valid flag. It is reusable by the other shared-resource arbiters in the design.
- Counters and FSM live in the top of this block.

Test Plan:
1. Reset sequence, then req=3'b001; source 0 sends "A","B" with last on "B" and tx_ready=1 -> grant=001 one clock after req, tx_data 0x41 then 0x42, msg_done pulses on 0x42, grant=000 for 16 clocks (GAP), busy high throughout.
2. req=3'b111 held, each source sends 1-byte messages -> grant sequence 001,010,100,001, each separated by 16 gap clocks.
3. tx_ready toggled 1,0,0,1 during a 3-byte message -> tx_data holds its value while tx_ready=0, req_ready[g] mirrors tx_ready, exactly 3 bytes are accepted, no duplicates.
4. TIMEOUT=20: source 1 is granted, sends 1 byte, then holds req_valid=0 -> abort pulses 20 cycles after the last valid, grant clears, source 2 (requesting) is granted after the gap.
5. GAP_CYCLES=0: back-to-back requests -> next grant asserts 2 clocks after the last byte (1 to IDLE, 1 to grant).
6. rst pulsed mid-message while source 2 is owner -> grant, tx_valid and busy drop asynchronously; after release with req=3'b101, source 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmitter arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Widest requester set any arbiter built on these helpers supports.
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned MAX_IDX_W = 3;

  function automatic logic [MAX_REQ-1:0] idx2onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle of the UART arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 8
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    busy;
  logic                    msg_done;
  logic                    abort;

  // Sources plus transmitter: everything around the arbiter.
  modport master (
    output req, req_data, req_valid, req_last, tx_ready,
    input  req_ready, grant, tx_data, tx_valid, busy, msg_done, abort
  );

  // The arbiter itself.
  modport slave (
    input  req, req_data, req_valid, req_last, tx_ready,
    output req_ready, grant, tx_data, tx_valid, busy, msg_done, abort
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit after ptr, wrapping.
module uart_tx_arbiter_rr_picker #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int unsigned cand;

  // Scan ptr+1, ptr+2, ... modulo N_REQ; the earliest requester wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin owner of the shared byte-wide UART transmitter.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 3,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t            state, state_d;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [N_REQ-1:0]  grant, grant_d;

  logic [N_REQ-1:0]  req_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              msg_done;
  logic              abort;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [DATA_W-1:0] src_data [N_REQ];

  // Split the flat per-source data bus into one byte per source.
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign src_data[i] = bus.req_data[i*DATA_W +: DATA_W];
  end

  uart_tx_arbiter_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State, round-robin pointer, counters and the registered grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= IDX_W'(N_REQ - 1);
      gap_cnt <= '0;
      to_cnt  <= '0;
      grant   <= '0;
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_ptr_d;
      gap_cnt <= gap_cnt_d;
      to_cnt  <= to_cnt_d;
      grant   <= grant_d;
    end
  end

  // Next-state logic and the combinational transmit path from the owner.
  // While granted, rr_ptr holds the owner index.
  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    gap_cnt_d = gap_cnt;
    to_cnt_d  = '0;
    grant_d   = grant;
    req_ready = '0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    msg_done  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_d  = N_REQ'(idx2onehot(MAX_IDX_W'(pick_idx)));
          rr_ptr_d = pick_idx;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        tx_valid          = bus.req_valid[rr_ptr];
        if (tx_valid) tx_data = src_data[rr_ptr];
        req_ready[rr_ptr] = bus.tx_ready;
        to_cnt_d          = tx_valid ? '0 : to_cnt + TO_W'(1);
        msg_done          = tx_valid && bus.tx_ready && bus.req_last[rr_ptr];
        abort             = !tx_valid && (to_cnt == TO_W'(TO_LAST));
        if (msg_done || abort) begin
          grant_d   = '0;
          to_cnt_d  = '0;
          gap_cnt_d = GAP_W'(GAP_LOAD);
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_cnt_d = gap_cnt - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.grant     = grant;
  assign bus.req_ready = req_ready;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.msg_done  = msg_done;
  assign bus.abort     = abort;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a gap=16 and a gap=0 instance share stimulus.
module tb_uart_tx_arbiter;

  localparam int EV_GRANT = 0;
  localparam int EV_BYTE  = 1;
  localparam int EV_ABORT = 2;

  typedef struct packed {
    logic       stall;
    logic       last;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    int         kind;
    logic [2:0] grant;
    logic [7:0] data;
    logic       last;
    int         dly;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [2:0]  req_v, valid_v, last_v;
  logic [23:0] data_v;
  logic        tx_ready_v = 1'b1;

  logic [2:0]  m_grant, m_req_ready;
  logic [7:0]  m_tx_data;
  logic        m_tx_valid, m_busy, m_msg_done, m_abort;

  ent_t q0[$], q1[$], q2[$];
  ev_t  sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_cyc = 0;

  uart_tx_arbiter_if #(.N_REQ(3), .DATA_W(8)) bus_a ();
  uart_tx_arbiter_if #(.N_REQ(3), .DATA_W(8)) bus_b ();

  uart_tx_arbiter #(.N_REQ(3), .DATA_W(8), .GAP_CYCLES(16), .TIMEOUT(20)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  uart_tx_arbiter #(.N_REQ(3), .DATA_W(8), .GAP_CYCLES(0), .TIMEOUT(20)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  assign bus_a.req = req_v;      assign bus_b.req = req_v;
  assign bus_a.req_data = data_v; assign bus_b.req_data = data_v;
  assign bus_a.req_valid = valid_v; assign bus_b.req_valid = valid_v;
  assign bus_a.req_last = last_v;   assign bus_b.req_last = last_v;
  assign bus_a.tx_ready = tx_ready_v; assign bus_b.tx_ready = tx_ready_v;

  assign m_grant     = sel ? bus_b.grant     : bus_a.grant;
  assign m_req_ready = sel ? bus_b.req_ready : bus_a.req_ready;
  assign m_tx_data   = sel ? bus_b.tx_data   : bus_a.tx_data;
  assign m_tx_valid  = sel ? bus_b.tx_valid  : bus_a.tx_valid;
  assign m_busy      = sel ? bus_b.busy      : bus_a.busy;
  assign m_msg_done  = sel ? bus_b.msg_done  : bus_a.msg_done;
  assign m_abort     = sel ? bus_b.abort     : bus_a.abort;

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-source message queues.
  function automatic int qsize(input int s);
    case (s)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic ent_t qfront(input int s);
    case (s)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int s);
    case (s)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int s, input logic st, input logic l, input logic [7:0] d);
    ent_t e;
    e = '{stall: st, last: l, data: d};
    case (s)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qflush();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic push_ev(input int k, input logic [2:0] g, input logic [7:0] d,
                         input logic l, input int dly);
    ev_t e;
    e = '{kind: k, grant: g, data: d, last: l, dly: dly};
    sb.push_back(e);
  endtask

  // Source driver: retire accepted bytes, present the head of each queue.
  initial begin
    logic [2:0] acc;
    ent_t       e;
    req_v = '0; valid_v = '0; last_v = '0; data_v = '0;
    forever begin
      @(negedge clk);
      acc = valid_v & m_req_ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        if (acc[s] && qsize(s) > 0) qpop(s);
        if (qsize(s) > 0) begin
          e = qfront(s);
          req_v[s]          = 1'b1;
          valid_v[s]        = !e.stall;
          last_v[s]         = e.last;
          data_v[s*8 +: 8]  = e.data;
        end else begin
          req_v[s]          = 1'b0;
          valid_v[s]        = 1'b0;
          last_v[s]         = 1'b0;
          data_v[s*8 +: 8]  = 8'h00;
        end
      end
    end
  end

  task automatic take_ev(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d grant %b data %0h, required none (cycle %0d)",
               kind, m_grant, m_tx_data, cyc);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", kind, e.kind);
    chk("ev_grant", 32'(m_grant), 32'(e.grant));
    if (kind == EV_BYTE) begin
      chk("ev_tx_data", 32'(m_tx_data), 32'(e.data));
      chk("ev_msg_done", 32'(m_msg_done), 32'(e.last));
      chk("ev_req_ready", 32'(m_req_ready), 32'(e.grant));
    end
    if (kind == EV_ABORT) chk("ev_abort_tx_valid", 32'(m_tx_valid), 0);
    if (e.dly >= 0) chk("ev_delay", cyc - last_cyc, e.dly);
    last_cyc = cyc;
  endtask

  // Monitor: every grant rise, accepted byte and abort pops one expectation.
  initial begin
    logic [2:0] prev_grant;
    prev_grant = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_grant = '0;
      end else begin
        if (m_grant != 3'b000 && prev_grant == 3'b000) take_ev(EV_GRANT);
        if (m_tx_valid && tx_ready_v) take_ev(EV_BYTE);
        else if (m_msg_done) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_msg_done: got 1 without transfer, required 0 (cycle %0d)", cyc);
        end
        if (m_abort) take_ev(EV_ABORT);
        prev_grant = m_grant;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    qflush();
    tx_ready_v = 1'b1;
    #1;
    chk("rst_grant", 32'(m_grant), 0);
    chk("rst_req_ready", 32'(m_req_ready), 0);
    chk("rst_tx_valid", 32'(m_tx_valid), 0);
    chk("rst_tx_data", 32'(m_tx_data), 0);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_msg_done", 32'(m_msg_done), 0);
    chk("rst_abort", 32'(m_abort), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_sb"}, sb.size(), 0);
    chk({tag, "_drain_busy"}, 32'(m_busy), 0);
  endtask

  task automatic wait_pulse(input bit use_abort, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (use_abort ? m_abort : m_msg_done) seen = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    bit ok;

    // 1: single two-byte message, grant latency and gap window.
    sel = 1'b0;
    do_reset();
    push_ev(EV_GRANT, 3'b001, 8'h00, 1'b0, -1);
    push_ev(EV_BYTE,  3'b001, 8'h41, 1'b0, 0);
    push_ev(EV_BYTE,  3'b001, 8'h42, 1'b1, 1);
    qpush(0, 1'b0, 1'b0, 8'h41);
    qpush(0, 1'b0, 1'b1, 8'h42);
    @(posedge clk);
    @(negedge clk);
    chk("t1_grant_req_cycle", 32'(m_grant), 0);
    @(negedge clk);
    chk("t1_grant_next_cycle", 32'(m_grant), 32'(3'b001));
    chk("t1_busy_grant", 32'(m_busy), 1);
    wait_pulse(1'b0, 10, seen);
    chk("t1_msg_done_seen", 32'(seen), 1);
    ok = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (!(m_busy && m_grant == 3'b000)) ok = 1'b0;
    end
    chk("t1_gap_busy_16", 32'(ok), 1);
    @(negedge clk);
    chk("t1_gap_end_busy", 32'(m_busy), 0);
    drain("t1");

    // 2: all three request, round-robin 0,1,2,0 with 16-clock gaps.
    do_reset();
    push_ev(EV_GRANT, 3'b001, 8'h00, 1'b0, -1);
    push_ev(EV_BYTE,  3'b001, 8'h10, 1'b1, 0);
    push_ev(EV_GRANT, 3'b010, 8'h00, 1'b0, 18);
    push_ev(EV_BYTE,  3'b010, 8'h11, 1'b1, 0);
    push_ev(EV_GRANT, 3'b100, 8'h00, 1'b0, 18);
    push_ev(EV_BYTE,  3'b100, 8'h12, 1'b1, 0);
    push_ev(EV_GRANT, 3'b001, 8'h00, 1'b0, 18);
    push_ev(EV_BYTE,  3'b001, 8'h13, 1'b1, 0);
    qpush(0, 1'b0, 1'b1, 8'h10);
    qpush(0, 1'b0, 1'b1, 8'h13);
    qpush(1, 1'b0, 1'b1, 8'h11);
    qpush(2, 1'b0, 1'b1, 8'h12);
    drain("t2");

    // 3: transmitter back-pressure 1,0,0,1 inside a three-byte message.
    do_reset();
    push_ev(EV_GRANT, 3'b010, 8'h00, 1'b0, -1);
    push_ev(EV_BYTE,  3'b010, 8'h31, 1'b0, 0);
    push_ev(EV_BYTE,  3'b010, 8'h32, 1'b0, 3);
    push_ev(EV_BYTE,  3'b010, 8'h33, 1'b1, 1);
    qpush(1, 1'b0, 1'b0, 8'h31);
    qpush(1, 1'b0, 1'b0, 8'h32);
    qpush(1, 1'b0, 1'b1, 8'h33);
    @(posedge clk);
    @(posedge clk);
    #1 tx_ready_v = 1'b1;
    @(posedge clk);
    #1 tx_ready_v = 1'b0;
    @(negedge clk);
    chk("t3_hold_data_a", 32'(m_tx_data), 32'h32);
    chk("t3_hold_valid", 32'(m_tx_valid), 1);
    chk("t3_hold_req_ready", 32'(m_req_ready), 0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_hold_data_b", 32'(m_tx_data), 32'h32);
    @(posedge clk);
    #1 tx_ready_v = 1'b1;
    drain("t3");

    // 4: owner stalls after one byte; revoked after 20 idle clocks.
    do_reset();
    push_ev(EV_GRANT, 3'b010, 8'h00, 1'b0, -1);
    push_ev(EV_BYTE,  3'b010, 8'h41, 1'b0, 0);
    push_ev(EV_ABORT, 3'b010, 8'h00, 1'b0, 20);
    push_ev(EV_GRANT, 3'b100, 8'h00, 1'b0, 18);
    push_ev(EV_BYTE,  3'b100, 8'h43, 1'b1, 0);
    qpush(1, 1'b0, 1'b0, 8'h41);
    qpush(1, 1'b1, 1'b1, 8'h42);
    qpush(2, 1'b0, 1'b1, 8'h43);
    wait_pulse(1'b1, 60, seen);
    chk("t4_abort_seen", 32'(seen), 1);
    q1.delete();
    drain("t4");

    // 5: zero-gap instance, next grant two clocks after the last byte.
    sel = 1'b1;
    do_reset();
    push_ev(EV_GRANT, 3'b001, 8'h00, 1'b0, -1);
    push_ev(EV_BYTE,  3'b001, 8'h51, 1'b1, 0);
    push_ev(EV_GRANT, 3'b010, 8'h00, 1'b0, 2);
    push_ev(EV_BYTE,  3'b010, 8'h52, 1'b1, 0);
    qpush(0, 1'b0, 1'b1, 8'h51);
    qpush(1, 1'b0, 1'b1, 8'h52);
    drain("t5");

    // 6: asynchronous reset while source 2 owns the transmitter.
    sel = 1'b0;
    do_reset();
    tx_ready_v = 1'b0;
    push_ev(EV_GRANT, 3'b100, 8'h00, 1'b0, -1);
    qpush(2, 1'b0, 1'b0, 8'h61);
    qpush(2, 1'b0, 1'b0, 8'h62);
    qpush(2, 1'b0, 1'b1, 8'h63);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t6_owner_before", 32'(m_grant), 32'(3'b100));
    chk("t6_valid_before", 32'(m_tx_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_grant", 32'(m_grant), 0);
    chk("t6_async_tx_valid", 32'(m_tx_valid), 0);
    chk("t6_async_busy", 32'(m_busy), 0);
    chk("t6_async_req_ready", 32'(m_req_ready), 0);
    qflush();
    tx_ready_v = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_ev(EV_GRANT, 3'b001, 8'h00, 1'b0, -1);
    push_ev(EV_BYTE,  3'b001, 8'h64, 1'b1, 0);
    push_ev(EV_GRANT, 3'b100, 8'h00, 1'b0, 18);
    push_ev(EV_BYTE,  3'b100, 8'h65, 1'b1, 0);
    qpush(0, 1'b0, 1'b1, 8'h64);
    qpush(2, 1'b0, 1'b1, 8'h65);
    drain("t6");

    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
